cpu_run_monitor: RTL and testbench
==================================

// Module: cpu_run_monitor
// PURPOSE
// - Synthesizable pass/fail/timeout/hang monitor for CPU benches; replaces per-test hard-coded checks.
// - Sits beside `cpu`, snooping its data-memory write port (memwrite, dataaddr, writedata) and pc.
// - Produces sticky verdict flags, a cycle count and a retire-proxy count for the bench to $stop on.
// PARAMETERS
// - W           32   data/address/pc width
// - CNT_W       32   width of cycle_count / pc_changes counters
// - PASS_ADDR   10   store address that signals success
// - FAIL_ADDR   16   store address that signals failure
// - MAX_CYCLES  190  cycles in RUN before TIMEOUT verdict (0 = disabled)
// - HANG_LIMIT  64   consecutive cycles with unchanged pc before HANG verdict (0 = disabled)
// - ARM_DELAY   1    cycles after reset release before matches/hang are evaluated
// - PASS_DATA   0    required writedata on pass store (only with MON_DATA_CHECK_EN)
// PORTS
// - clk          in   1      clock, all state on rising edge
// - reset        in   1      synchronous, active-high
// - memwrite     in   1      cpu store strobe
// - dataaddr     in   W      cpu store address
// - writedata    in   W      cpu store data
// - pc           in   W      cpu program counter
// - done         out  1      verdict reached (sticky)
// - pass         out  1      PASS verdict (sticky)
// - fail         out  1      FAIL verdict (sticky)
// - timeout      out  1      TIMEOUT verdict (sticky)
// - hang         out  1      HANG verdict (sticky)
// - cycle_count  out  CNT_W  cycles spent in ARM+RUN
// - pc_changes   out  CNT_W  cycles in RUN where pc differs from previous cycle
// BEHAVIOUR
// - Reset: state=ARM; all flags 0; cycle_count=0; pc_changes=0; arm/hang counters 0; pc_q=pc.
// - FSM: ARM -> RUN -> {PASS, FAIL, TIMEOUT, HANG}; verdict states absorb until reset.
// - ARM: counts ARM_DELAY cycles, ignores bus; ARM_DELAY=0 enters RUN on first cycle after reset.
// - RUN: store_hit = memwrite & (dataaddr == addr param); evaluated combinationally, verdict flag
//   registered -> flag rises 1 cycle after the matching store cycle.
// - Priority in one cycle: FAIL > PASS > HANG > TIMEOUT (PASS_ADDR==FAIL_ADDR -> FAIL).
// - TIMEOUT: asserted on cycle where cycle_count reaches MAX_CYCLES while still RUN and no hit.
// - HANG: pc == pc_q for HANG_LIMIT consecutive RUN cycles; any pc change clears the run counter.
// - pc_changes increments when pc != pc_q in RUN; pc_q updates every cycle.
// - Counters saturate at all-ones; never wrap. Frozen (hold value) once a verdict is reached.
// - done = pass|fail|timeout|hang; exactly one verdict flag ever set per reset epoch.
// - memwrite with X/Z address treated as no-hit (compare uses ===1'b1 on the equality result in sim).
// - Reset mid-RUN or in a verdict state: all outputs return to reset values next edge.
// CONFIGURATION
// - MON_DATA_CHECK_EN defined: PASS requires writedata == PASS_DATA; pass-addr store with
//   other data -> FAIL verdict. FAIL_ADDR match unaffected by data.
// - MON_DATA_CHECK_EN undefined: writedata ignored; PASS on address match alone.
// TESTING
// - Store addr 10 at RUN cycle 18 -> pass=1, done=1 next cycle; cycle_count frozen at 19 (ARM_DELAY=1).
// - Store addr 16 (jump-skip bug) -> fail=1 next cycle; pass stays 0 for rest of epoch.
// - No matching store, pc advancing by 4 each 4 cycles -> timeout=1 when cycle_count reaches 190.
// - pc held constant 64 cycles in RUN -> hang=1; pc change at cycle 63 resets counter, no hang.
// - Addr 10 and addr 16 stores in same cycle window + reset asserted in PASS -> flags clear,
//   new epoch reaches fail on next addr-16 store.
// - MON_DATA_CHECK_EN, PASS_DATA=0xa: store(10, 0xa) -> pass; store(10, 0xf) -> fail.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: pass/fail/timeout/hang verdict monitor that sits beside a CPU
// and snoops its data-memory write port and program counter.
//
// Ports:
//   clk          in   1      clock, all state on rising edge
//   reset        in   1      synchronous, active-high
//   memwrite     in   1      cpu store strobe
//   dataaddr     in   W      cpu store address
//   writedata    in   W      cpu store data
//   pc           in   W      cpu program counter
//   done         out  1      any verdict reached (sticky)
//   pass         out  1      PASS verdict (sticky)
//   fail         out  1      FAIL verdict (sticky)
//   timeout      out  1      TIMEOUT verdict (sticky)
//   hang         out  1      HANG verdict (sticky)
//   cycle_count  out  CNT_W  cycles spent in ARM+RUN (saturating, frozen at verdict)
//   pc_changes   out  CNT_W  RUN cycles where pc differed from the previous cycle
//
// Optional feature macro: MON_DATA_CHECK_EN
//   defined   -> a pass-address store must carry PASS_DATA, otherwise it is a FAIL
//   undefined -> writedata is ignored, PASS on address match alone

module cpu_run_monitor #(
    parameter int unsigned W          = 32,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned PASS_ADDR  = 10,
    parameter int unsigned FAIL_ADDR  = 16,
    parameter int unsigned MAX_CYCLES = 190,
    parameter int unsigned HANG_LIMIT = 64,
    parameter int unsigned ARM_DELAY  = 1,
    parameter int unsigned PASS_DATA  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [W-1:0]     dataaddr,
    input  logic [W-1:0]     writedata,
    input  logic [W-1:0]     pc,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic             hang,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] pc_changes
);

    typedef enum logic [2:0] {
        ST_ARM,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT,
        ST_HANG
    } state_e;

    // With no arming delay the first cycle after reset is already a RUN cycle.
    localparam state_e           RESET_STATE = (ARM_DELAY == 0) ? ST_RUN : ST_ARM;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] ARM_LIM     = CNT_W'(ARM_DELAY);
    localparam logic [CNT_W-1:0] MAX_CYC_LIM = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] HANG_LIM    = CNT_W'(HANG_LIMIT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    state_e           state_q;
    logic [W-1:0]     pc_q;
    logic [CNT_W-1:0] cycle_count_q;
    logic [CNT_W-1:0] pc_changes_q;
    logic [CNT_W-1:0] arm_cnt_q;
    logic [CNT_W-1:0] hang_cnt_q;
    logic             pass_q;
    logic             fail_q;
    logic             timeout_q;
    logic             hang_q;
    logic             done_q;

    logic             pass_hit_c;
    logic             fail_hit_c;
    logic             pass_ok_c;
    logic             fail_c;
    logic             pc_same_c;
    logic [CNT_W-1:0] cycle_count_d;
    logic [CNT_W-1:0] arm_cnt_d;
    logic [CNT_W-1:0] hang_cnt_d;
    logic             hang_trip_c;
    logic             timeout_trip_c;

    // Store matches; an unknown address or strobe must never count as a hit.
    always_comb begin
        pass_hit_c = (memwrite & (dataaddr == W'(PASS_ADDR))) === 1'b1;
        fail_hit_c = (memwrite & (dataaddr == W'(FAIL_ADDR))) === 1'b1;
    end

`ifdef MON_DATA_CHECK_EN
    // A pass-address store carrying the wrong data is itself a failure.
    always_comb begin
        pass_ok_c = pass_hit_c & ((writedata == W'(PASS_DATA)) === 1'b1);
        fail_c    = fail_hit_c | (pass_hit_c & ~pass_ok_c);
    end
`else
    logic unused_data_c;
    assign unused_data_c = ^{writedata, W'(PASS_DATA)};

    always_comb begin
        pass_ok_c = pass_hit_c;
        fail_c    = fail_hit_c;
    end
`endif

    // Next counter values and limit trips for the current cycle.
    always_comb begin
        pc_same_c      = (pc == pc_q);
        cycle_count_d  = sat_inc(cycle_count_q);
        arm_cnt_d      = sat_inc(arm_cnt_q);
        hang_cnt_d     = pc_same_c ? sat_inc(hang_cnt_q) : '0;
        hang_trip_c    = (HANG_LIMIT != 0) && pc_same_c && (hang_cnt_d >= HANG_LIM);
        timeout_trip_c = (MAX_CYCLES != 0) && (cycle_count_d >= MAX_CYC_LIM);
    end

    // Monitor FSM with registered verdict flags; verdict states hold everything.
    always_ff @(posedge clk) begin
        pc_q <= pc;
        if (reset) begin
            state_q       <= RESET_STATE;
            cycle_count_q <= '0;
            pc_changes_q  <= '0;
            arm_cnt_q     <= '0;
            hang_cnt_q    <= '0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            hang_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_ARM: begin
                    cycle_count_q <= cycle_count_d;
                    arm_cnt_q     <= arm_cnt_d;
                    if (arm_cnt_d >= ARM_LIM) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cycle_count_q <= cycle_count_d;
                    hang_cnt_q    <= hang_cnt_d;
                    if (!pc_same_c) begin
                        pc_changes_q <= sat_inc(pc_changes_q);
                    end
                    // Verdict priority: FAIL > PASS > HANG > TIMEOUT.
                    if (fail_c) begin
                        state_q <= ST_FAIL;
                        fail_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end else if (pass_ok_c) begin
                        state_q <= ST_PASS;
                        pass_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end else if (hang_trip_c) begin
                        state_q <= ST_HANG;
                        hang_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end else if (timeout_trip_c) begin
                        state_q   <= ST_TIMEOUT;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign hang        = hang_q;
    assign cycle_count = cycle_count_q;
    assign pc_changes  = pc_changes_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Testbench for cpu_run_monitor: directed scenarios plus randomized soak, all
// checked every cycle against an epoch-level reference model.
module tb_cpu_run_monitor;

    localparam int PASS_A = 10;
    localparam int FAIL_A = 16;
    localparam int MAXC   = 190;
    localparam int HANGL  = 64;
    localparam int ARMD   = 1;
    localparam int PDATA  = 0;

    localparam int V_NONE = 0;
    localparam int V_PASS = 1;
    localparam int V_FAIL = 2;
    localparam int V_TOUT = 3;
    localparam int V_HANG = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataaddr;
    logic [31:0] writedata;
    logic [31:0] pc;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic        hang;
    logic [31:0] cycle_count;
    logic [31:0] pc_changes;

    int total = 0;
    int bad   = 0;

    // Reference model: what has happened in this epoch, in plain counts.
    int          m_cycles;
    int          m_changes;
    int          m_still;
    int          m_armed;
    int          m_verdict;
    logic [31:0] m_prev_pc;

    cpu_run_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .dataaddr   (dataaddr),
        .writedata  (writedata),
        .pc         (pc),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .timeout    (timeout),
        .hang       (hang),
        .cycle_count(cycle_count),
        .pc_changes (pc_changes)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cycles  = 0;
        m_changes = 0;
        m_still   = 0;
        m_armed   = 0;
        m_verdict = V_NONE;
        m_prev_pc = pc;
    endtask

    task automatic model_step();
        bit at_pass;
        bit at_fail;
        bit good_pass;
        if (m_verdict == V_NONE) begin
            if (m_armed < ARMD) begin
                m_armed++;
                m_cycles++;
            end else begin
                m_cycles++;
                if (pc !== m_prev_pc) begin
                    m_changes++;
                    m_still = 0;
                end else begin
                    m_still++;
                end
                at_pass = (memwrite === 1'b1) && (dataaddr === 32'(PASS_A));
                at_fail = (memwrite === 1'b1) && (dataaddr === 32'(FAIL_A));
`ifdef MON_DATA_CHECK_EN
                good_pass = at_pass && (writedata === 32'(PDATA));
                if (at_pass && !good_pass) at_fail = 1'b1;
`else
                good_pass = at_pass;
`endif
                if (at_fail)                     m_verdict = V_FAIL;
                else if (good_pass)              m_verdict = V_PASS;
                else if (m_still >= HANGL)       m_verdict = V_HANG;
                else if (m_cycles >= MAXC)       m_verdict = V_TOUT;
            end
        end
        m_prev_pc = pc;
    endtask

    task automatic check(input string tag);
        logic [4:0] exp_f;
        logic [4:0] got_f;
        exp_f = {m_verdict == V_PASS, m_verdict == V_FAIL, m_verdict == V_TOUT,
                 m_verdict == V_HANG, m_verdict != V_NONE};
        got_f = {pass, fail, timeout, hang, done};
        total++;
        assert (got_f === exp_f) else begin
            bad++;
            $error("FAIL %s flags{p,f,t,h,d} got=%b exp=%b", tag, got_f, exp_f);
        end
        total++;
        assert (cycle_count === 32'(m_cycles)) else begin
            bad++;
            $error("FAIL %s cycle_count got=%0d exp=%0d", tag, cycle_count, m_cycles);
        end
        total++;
        assert (pc_changes === 32'(m_changes)) else begin
            bad++;
            $error("FAIL %s pc_changes got=%0d exp=%0d", tag, pc_changes, m_changes);
        end
    endtask

    task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] p);
        memwrite  = mw;
        dataaddr  = a;
        writedata = d;
        pc        = p;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        #1;
        check(tag);
    endtask

    function automatic logic [31:0] idle_addr();
        return 32'($urandom_range(1000, 17));
    endfunction

    task automatic do_reset(input logic [31:0] p);
        reset = 1'b1;
        drive(1'b0, 32'd0, 32'd0, p);
        step("reset");
        step("reset");
        reset = 1'b0;
    endtask

    task automatic expect_bit(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic expect_cnt(input string tag, input logic [31:0] got, input int exp);
        total++;
        assert (got === 32'(exp)) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        logic [31:0] pcv;
        int          hold_pct;

        reset = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'h100);

        // Reset state.
        do_reset(32'h100);
        expect_bit("reset_done", done, 1'b0);
        expect_cnt("reset_cycles", cycle_count, 0);

        // PASS: store to pass address on the 18th RUN cycle.
        pcv = 32'h100;
        for (int i = 0; i < 18; i++) begin
            drive(1'($urandom % 2), idle_addr(), $urandom, pcv);
            step("pass_pre");
            pcv += 4;
        end
        drive(1'b1, 32'(PASS_A), 32'(PDATA), pcv);
        step("pass_store");
        expect_bit("pass_flag", pass, 1'b1);
        expect_bit("pass_done", done, 1'b1);
        expect_cnt("pass_cycles", cycle_count, 19);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, (i % 2 == 0) ? 32'(FAIL_A) : 32'(PASS_A), $urandom, pcv);
            step("pass_hold");
            pcv += 4;
        end
        expect_bit("pass_no_fail", fail, 1'b0);
        expect_cnt("pass_frozen", cycle_count, 19);

        // FAIL: store to fail address, later pass-address stores ignored.
        do_reset(32'h200);
        pcv = 32'h200;
        for (int i = 0; i < 12; i++) begin
            drive(1'($urandom % 2), idle_addr(), $urandom, pcv);
            step("fail_pre");
            pcv += 4;
        end
        drive(1'b1, 32'(FAIL_A), $urandom, pcv);
        step("fail_store");
        expect_bit("fail_flag", fail, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(PASS_A), 32'(PDATA), pcv);
            step("fail_hold");
        end
        expect_bit("fail_no_pass", pass, 1'b0);

        // TIMEOUT: pc advances by 4 every 4 cycles, no matching stores.
        do_reset(32'h300);
        pcv = 32'h300;
        for (int i = 0; i < 200; i++) begin
            if (i % 4 == 3) pcv += 4;
            drive(1'($urandom % 2), idle_addr(), $urandom, pcv);
            step("timeout_run");
        end
        expect_bit("timeout_flag", timeout, 1'b1);
        expect_cnt("timeout_cycles", cycle_count, MAXC);

        // HANG: pc never moves.
        do_reset(32'h400);
        for (int i = 0; i < 70; i++) begin
            drive(1'b0, idle_addr(), $urandom, 32'h400);
            step("hang_run");
        end
        expect_bit("hang_flag", hang, 1'b1);
        expect_cnt("hang_cycles", cycle_count, 1 + HANGL);

        // No HANG: a single pc change on RUN cycle 63 restarts the run.
        do_reset(32'h500);
        drive(1'b0, 32'd0, 32'd0, 32'h500);
        step("nohang_arm");
        for (int i = 1; i <= 70; i++) begin
            drive(1'b0, idle_addr(), $urandom, (i >= 63) ? 32'h504 : 32'h500);
            step("nohang_run");
        end
        expect_bit("nohang_flag", hang, 1'b0);
        expect_bit("nohang_done", done, 1'b0);

        // Pass then fail store back-to-back, reset in PASS, new epoch fails.
        do_reset(32'h600);
        drive(1'b0, 32'd0, 32'd0, 32'h600);
        step("both_arm");
        drive(1'b1, 32'(PASS_A), 32'(PDATA), 32'h604);
        step("both_pass");
        drive(1'b1, 32'(FAIL_A), 32'd0, 32'h608);
        step("both_fail_ignored");
        expect_bit("both_pass_flag", pass, 1'b1);
        expect_bit("both_fail_flag", fail, 1'b0);
        reset = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'h700);
        step("reset_in_pass");
        expect_bit("reset_clears_pass", pass, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, idle_addr(), 32'd0, 32'h700 + 32'(4 * i));
            step("epoch2_pre");
        end
        drive(1'b1, 32'(FAIL_A), 32'd0, 32'h720);
        step("epoch2_fail");
        expect_bit("epoch2_fail_flag", fail, 1'b1);

        // Unknown store address never counts as a hit.
        do_reset(32'h800);
        drive(1'b0, 32'd0, 32'd0, 32'h800);
        step("x_arm");
        drive(1'b1, 32'bx, 32'd0, 32'h804);
        step("x_addr");

        // Randomized soak with occasional mid-run resets.
        for (int e = 0; e < 4; e++) begin
            hold_pct = 20 + 25 * e;
            do_reset(32'($urandom));
            pcv = 32'($urandom);
            for (int i = 0; i < 160; i++) begin
                int r;
                r = int'($urandom % 60);
                if (int'($urandom % 100) >= hold_pct) pcv = 32'($urandom % 64) << 2;
                if (r == 0)      drive(1'($urandom % 2), 32'(PASS_A), 32'($urandom % 2), pcv);
                else if (r == 1) drive(1'($urandom % 2), 32'(FAIL_A), $urandom, pcv);
                else             drive(1'($urandom % 2), idle_addr(), $urandom, pcv);
                reset = ($urandom % 120 == 0);
                step("soak");
            end
            reset = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
